// File: rtl/tile_lane_engine_pkg.sv
// Shared definitions for the tile lane engine.
//   state_t     : game FSM encoding (IDLE / RUN / OVER)
//   row_t       : one board row (valid, lane, hit)
//   LANES       : number of key lanes
//   LFSR_TAPS   : feedback mask for taps 8,6,5,4 of the spawn LFSR
//   lane_onehot : lane index -> one-hot key pattern
//   lfsr_next   : one Fibonacci LFSR step (shift left, feedback into bit 0)
package tile_lane_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int LANES = 4;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Field order gives the row offsets: valid at bit 3, lane at bits 2:1, hit at bit 0.
  typedef struct packed {
    logic       valid;
    logic [1:0] lane;
    logic       hit;
  } row_t;

  localparam row_t ROW_EMPTY = 4'b0000;

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tile_lane_engine_lfsr8.sv
// 8-bit Fibonacci LFSR that drives tile spawning.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset, loads seed
//   load  in  reload seed (start of a new game)
//   seed  in  [7:0] load value, must be nonzero so the sequence never sticks at 0
//   adv   in  advance one step
//   q     out [7:0] current LFSR value
module lfsr8
  import tile_lane_engine_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       adv,
  output logic [7:0] q
);

  // LFSR register: reset/load take priority over advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_next(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/tile_lane_engine.sv
// Falling-tile game core. Scrolls a ROWS-deep, 4-lane board one row on every
// counter wrap, spawns tiles from an LFSR, judges key presses against row 0
// and keeps a saturating score.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   start     in  game enable level
//   count     in  [7:0] counter value
//   reset_at  in  [7:0] counter period (0 = 256)
//   key       in  [3:0] debounced lane buttons
//   tiles     out [4*ROWS-1:0] one-hot lane per row for live unhit tiles
//   score     out [7:0] tiles hit, saturating at 255
//   game_over out high in OVER
//   running   out high in RUN
module tile_lane_engine
  import tile_lane_engine_pkg::*;
#(
  parameter int         ROWS = 4,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        count,
  input  logic [7:0]        reset_at,
  input  logic [3:0]        key,
  output logic [4*ROWS-1:0] tiles,
  output logic [7:0]        score,
  output logic              game_over,
  output logic              running
);

  state_t     state_r, state_n;
  row_t       rows_r [ROWS];
  row_t       rows_n [ROWS];
  row_t       row0_s;
  logic [7:0] score_r, score_n;
  logic [3:0] key_prev_r;
  logic [3:0] key_edge_s;
  logic [7:0] last_s;
  logic       step_s;
  logic       over_s;
  logic       lfsr_load_s;
  logic       lfsr_adv_s;
  logic [7:0] lfsr_q;
  logic       unused_lfsr_high;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load_s),
    .seed  (SEED),
    .adv   (lfsr_adv_s),
    .q     (lfsr_q)
  );

  // Only the low five bits choose the spawned tile; the rest only feed the LFSR itself.
  assign unused_lfsr_high = ^lfsr_q[7:5];

  assign key_edge_s = key & ~key_prev_r;
  assign last_s     = (reset_at == 8'd0) ? 8'd255 : reset_at - 8'd1;
  assign step_s     = (state_r == ST_RUN) && start && (count == last_s);

  // Judge, scroll and FSM next-state; judge runs first so a hit on the step cycle is not a miss.
  always_comb begin
    state_n     = state_r;
    score_n     = score_r;
    rows_n      = rows_r;
    row0_s      = rows_r[0];
    over_s      = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_adv_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        for (int r = 0; r < ROWS; r++) rows_n[r] = ROW_EMPTY;
        if (start) begin
          state_n     = ST_RUN;
          score_n     = 8'd0;
          lfsr_load_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!start) begin
          state_n = ST_IDLE;
          for (int r = 0; r < ROWS; r++) rows_n[r] = ROW_EMPTY;
        end else begin
          if (key_edge_s != 4'd0) begin
            if (row0_s.valid && !row0_s.hit && (key_edge_s == lane_onehot(row0_s.lane))) begin
              row0_s.hit = 1'b1;
              score_n    = (score_r == 8'd255) ? score_r : score_r + 8'd1;
            end else begin
              over_s = 1'b1;
            end
          end else begin
            over_s = 1'b0;
          end
          rows_n[0] = row0_s;
          // A live tile still unhit in row 0 when the board scrolls is a miss.
          if (step_s && !over_s) begin
            if (row0_s.valid && !row0_s.hit) begin
              over_s = 1'b1;
            end else begin
              for (int r = 0; r < ROWS - 1; r++) rows_n[r] = rows_r[r+1];
              rows_n[ROWS-1] = {(lfsr_q[4:2] != 3'd0), lfsr_q[1:0], 1'b0};
              lfsr_adv_s     = 1'b1;
            end
          end else begin
            lfsr_adv_s = 1'b0;
          end
          state_n = over_s ? ST_OVER : ST_RUN;
        end
      end
      ST_OVER: begin
        if (!start) begin
          state_n = ST_IDLE;
          for (int r = 0; r < ROWS; r++) rows_n[r] = ROW_EMPTY;
        end else begin
          state_n = ST_OVER;
        end
      end
      default: begin
        state_n = ST_IDLE;
        for (int r = 0; r < ROWS; r++) rows_n[r] = ROW_EMPTY;
      end
    endcase
  end

  // State, board, score and key history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      score_r    <= 8'd0;
      key_prev_r <= 4'd0;
      for (int r = 0; r < ROWS; r++) rows_r[r] <= ROW_EMPTY;
    end else begin
      state_r    <= state_n;
      score_r    <= score_n;
      key_prev_r <= key;
      for (int r = 0; r < ROWS; r++) rows_r[r] <= rows_n[r];
    end
  end

  // Render live, unhit tiles as one-hot lane nibbles.
  always_comb begin
    tiles = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_r[r].valid && !rows_r[r].hit) begin
        tiles[4*r +: 4] = lane_onehot(rows_r[r].lane);
      end else begin
        tiles[4*r +: 4] = 4'd0;
      end
    end
  end

  assign score     = score_r;
  assign game_over = (state_r == ST_OVER);
  assign running   = (state_r == ST_RUN);

endmodule

// File: tb/tb_tile_lane_engine.sv
// Scoreboard bench for tile_lane_engine: a behavioural game model predicts the
// outputs after every clock; a monitor compares them one cycle later.
module tb_tile_lane_engine;

  localparam int         ROWS = 4;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [7:0]        count, reset_at;
  logic [3:0]        key;
  logic [4*ROWS-1:0] tiles;
  logic [7:0]        score;
  logic              game_over, running;

  always #5 clk = ~clk;

  tile_lane_engine #(.ROWS(ROWS), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .reset_at(reset_at),
    .key(key), .tiles(tiles), .score(score), .game_over(game_over), .running(running)
  );

  typedef struct packed {
    logic [4*ROWS-1:0] tiles;
    logic [7:0]        score;
    logic              go;
    logic              run;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // behavioural game state
  bit         m_valid [ROWS];
  int         m_lane  [ROWS];
  bit         m_hit   [ROWS];
  int         m_score;
  int         m_mode;
  int         m_lfsr;
  logic [3:0] m_kprev;

  int         cnt = 0;
  logic [7:0] ra_next = 8'd4;
  int         hold_left = 0;

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
    end
  endtask

  function automatic int period_last(input logic [7:0] ra);
    return (ra == 8'd0) ? 255 : int'(ra) - 1;
  endfunction

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) begin
      m_valid[r] = 1'b0; m_lane[r] = 0; m_hit[r] = 1'b0;
    end
  endtask

  // Advance the spawn LFSR: feedback is bit7^bit5^bit4^bit3, shifted in at the bottom.
  task automatic lfsr_step();
    int fb;
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 255;
  endtask

  // Apply one clock of game rules to the model using the inputs being driven now.
  task automatic model_clock();
    logic [3:0]        edg;
    bit                lose;
    exp_t              e;
    logic [4*ROWS-1:0] t;
    logic [3:0]        onehot;
    if (reset) begin
      clear_board(); m_score = 0; m_mode = M_IDLE; m_kprev = 4'd0; m_lfsr = SEED;
    end else begin
      edg = key & ~m_kprev;
      m_kprev = key;
      if (m_mode == M_IDLE) begin
        clear_board();
        if (start) begin m_mode = M_PLAY; m_score = 0; m_lfsr = SEED; end
      end else if (!start) begin
        m_mode = M_IDLE; clear_board();
      end else if (m_mode == M_PLAY) begin
        lose = 1'b0;
        if (edg != 4'd0) begin
          onehot = 4'b0001 << m_lane[0];
          if (m_valid[0] && !m_hit[0] && edg == onehot) begin
            m_hit[0] = 1'b1;
            if (m_score < 255) m_score++;
          end else lose = 1'b1;
        end
        if (!lose && int'(count) == period_last(reset_at)) begin
          if (m_valid[0] && !m_hit[0]) lose = 1'b1;
          else begin
            for (int r = 0; r < ROWS - 1; r++) begin
              m_valid[r] = m_valid[r+1]; m_lane[r] = m_lane[r+1]; m_hit[r] = m_hit[r+1];
            end
            m_valid[ROWS-1] = ((m_lfsr >> 2) & 7) != 0;
            m_lane[ROWS-1]  = m_lfsr & 3;
            m_hit[ROWS-1]   = 1'b0;
            lfsr_step();
          end
        end
        if (lose) m_mode = M_OVER;
      end
    end
    t = '0;
    for (int r = 0; r < ROWS; r++) begin
      onehot = 4'b0001 << m_lane[r];
      if (m_valid[r] && !m_hit[r]) t[4*r +: 4] = onehot;
    end
    e.tiles = t;
    e.score = 8'(m_score);
    e.go    = (m_mode == M_OVER);
    e.run   = (m_mode == M_PLAY);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and predict the result.
  task automatic tick(input bit r, input bit s, input logic [3:0] k);
    @(negedge clk);
    if (reset_at != ra_next) cnt = 0;
    reset_at = ra_next;
    reset = r; start = s; key = k; count = 8'(cnt);
    model_clock();
    cnt = (cnt >= period_last(reset_at)) ? 0 : cnt + 1;
  endtask

  // A player that presses the lane of the row-0 tile, sometimes late (on the step cycle).
  task automatic bot_key(input int hold_len, output logic [3:0] k);
    logic [3:0] need;
    need = 4'd0;
    if (m_mode == M_PLAY && m_valid[0] && !m_hit[0]) need = 4'b0001 << m_lane[0];
    if (need != 4'd0 && (m_kprev & need) == 4'd0 &&
        ($urandom_range(0, 1) == 0 || cnt == period_last(ra_next))) begin
      hold_left = hold_len - 1;
      k = need;
    end else if (hold_left > 0 && (m_kprev & need) == 4'd0) begin
      hold_left--;
      k = m_kprev;
    end else begin
      hold_left = 0;
      k = 4'd0;
    end
  endtask

  // Monitor: one prediction per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tiles", int'(tiles), int'(e.tiles));
        check("score", int'(score), int'(e.score));
        check("game_over", int'(game_over), int'(e.go));
        check("running", int'(running), int'(e.run));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] k;
    int budget;
    reset = 1'b1; start = 1'b0; key = 4'd0; count = 8'd0; reset_at = 8'd4;
    clear_board(); m_score = 0; m_mode = M_IDLE; m_kprev = 4'd0; m_lfsr = SEED;

    // reset, then start
    tick(1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'd0);

    // no keys: tiles scroll down until a miss freezes the board
    for (int c = 0; c < 40; c++) tick(1'b0, 1'b1, 4'd0);
    tick(1'b0, 1'b0, 4'd0);

    // long period with held keys: holding must not score twice
    ra_next = 8'd12;
    tick(1'b0, 1'b1, 4'd0);
    for (int c = 0; c < 200; c++) begin
      bot_key(10, k);
      tick(1'b0, 1'b1, k);
    end
    tick(1'b0, 1'b0, 4'd0);

    // play until the score saturates, then a few more hits
    ra_next = 8'd3;
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'd0);
    budget = 8000;
    while (m_score < 255 && budget > 0) begin
      if (m_mode != M_PLAY) begin
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 4'd0);
      end else begin
        bot_key(1, k);
        tick(1'b0, 1'b1, k);
      end
      budget--;
    end
    check("sat_reached", m_score, 255);
    for (int c = 0; c < 40; c++) begin
      bot_key(1, k);
      tick(1'b0, 1'b1, k);
    end
    // drop start: board clears, score kept; restart clears score and reseeds
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    for (int c = 0; c < 30; c++) tick(1'b0, 1'b1, 4'd0);

    // randomized games: random keys, periods (including 1 and 256), start drops, resets
    for (int g = 0; g < 12; g++) begin
      case ($urandom_range(0, 4))
        0: ra_next = 8'd0;
        1: ra_next = 8'd1;
        2: ra_next = 8'd2;
        3: ra_next = 8'd3;
        default: ra_next = 8'd5;
      endcase
      tick(1'b0, 1'b0, 4'd0);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 3) == 0) k = 4'($urandom_range(0, 15));
        else bot_key(1, k);
        tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) != 0), k);
      end
    end

    @(negedge clk);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
